ex_regaddr_scoreboard: RTL and testbench
========================================

EX_REGADDR_SCOREBOARD -- requirements
Module: ex_regaddr_scoreboard

Interface
REQ-001 Parameter INSTR_W, default 16, instruction width; SHALL satisfy INSTR_W >= 3*ADDR_W+1.
REQ-002 Parameter ADDR_W, default 5, register address width; NREGS = 2**ADDR_W.
REQ-003 Parameter CNT_W, default 16, stall counter width.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  in  1  instruction present.
REQ-007 instr  in  INSTR_W  instruction: rd=[ADDR_W-1:0], rt=[2*ADDR_W-1:ADDR_W], rs=[3*ADDR_W-1:2*ADDR_W], dst_sel=[INSTR_W-1].
REQ-008 in_ready  out  1  instruction accepted this cycle when in_valid also high.
REQ-009 flush  in  1  discard output stage and clear scoreboard.
REQ-010 wb_valid  in  1  writeback completing this cycle.
REQ-011 wb_addr  in  ADDR_W  register written back.
REQ-012 out_valid  out  1  decoded fields valid.
REQ-013 out_ready  in  1  downstream accepts output.
REQ-014 out_rs, out_rt, out_rd, out_dst  out  ADDR_W each  decoded source, target, rd fields and selected destination.
REQ-015 stall  out  1  in_valid high and in_ready low.
REQ-016 pending  out  NREGS  scoreboard, bit i = register i has an outstanding write.
REQ-017 stall_cnt  out  CNT_W  count of cycles with stall high.

Function
REQ-018 Decode: dst = rt when dst_sel=1, else rd.
REQ-019 Effective pending eff[i] = pending[i] and not (wb_valid and wb_addr==i) (same-cycle writeback bypass).
REQ-020 hazard = eff[rs] or eff[rt]; register 0 never hazards.
REQ-021 in_ready = not flush and not hazard and (not out_valid or out_ready); combinational.
REQ-022 Accept = in_valid and in_ready; on accept, out_rs/out_rt/out_rd/out_dst register the decoded fields and out_valid sets next cycle (latency 1).
REQ-023 Without accept, out_valid clears when out_ready is high and holds otherwise; out_* fields hold while out_valid and not out_ready.
REQ-024 Scoreboard update: bit wb_addr cleared on wb_valid; bit dst set on accept when dst != 0; same-address set and clear in one cycle -> bit ends set.
REQ-025 Bit 0 of pending SHALL remain 0 always.
REQ-026 flush: next cycle out_valid=0 and pending=0; no accept in a flush cycle; flush overrides wb_valid and accept.
REQ-027 stall_cnt increments by 1 each cycle stall is high; saturates at 2**CNT_W-1, no wrap.
REQ-028 wb_valid for a register not pending is harmless (bit stays 0).

Reset
REQ-029 rst_n low: immediately out_valid=0, out_rs=out_rt=out_rd=out_dst=0, pending=0, stall_cnt=0, independent of clk.
REQ-030 Reset mid-operation discards held output and all outstanding writes; first accept possible on the first rising edge after rst_n rises.

Verification
REQ-031 instr=16'h0443, in_valid=1, out_ready=1, empty scoreboard -> in_ready=1; next cycle out_valid=1, out_rs=1, out_rt=2, out_rd=3, out_dst=3, pending=32'h8.
REQ-032 After REQ-031, instr=16'h0C04 (rs=3) -> in_ready=0, stall=1, stall_cnt increments each cycle; wb_valid=1, wb_addr=3 -> accepted in that same cycle, pending then 32'h10.
REQ-033 instr=16'h8443 (dst_sel=1) -> out_dst=2, pending bit 2 set; instr with rd=0, dst_sel=0 -> pending unchanged.
REQ-034 out_valid=1, out_ready=0 for 3 cycles with new in_valid -> in_ready=0, out_* stable; out_ready=1 -> new instruction accepted same cycle.
REQ-035 Accept dst=5 with wb_valid=1, wb_addr=5 same cycle -> pending bit 5 =1; then flush=1 -> next cycle pending=0, out_valid=0.
REQ-036 rst_n low mid-stall with pending=32'h8, stall_cnt=7 -> all outputs 0 without a clock edge; CNT_W=2 run of 6 stall cycles -> stall_cnt=3.

Source files
------------

// File: rtl/ex_regaddr_scoreboard.sv
// Register-address decode stage with a write-pending scoreboard.
// Holds back instructions whose source registers still await writeback.
module ex_regaddr_scoreboard #(
    parameter int unsigned INSTR_W = 16,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [INSTR_W-1:0]     instr,
    output logic                   in_ready,
    input  logic                   flush,
    input  logic                   wb_valid,
    input  logic [ADDR_W-1:0]      wb_addr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADDR_W-1:0]      out_rs,
    output logic [ADDR_W-1:0]      out_rt,
    output logic [ADDR_W-1:0]      out_rd,
    output logic [ADDR_W-1:0]      out_dst,
    output logic                   stall,
    output logic [2**ADDR_W-1:0]   pending,
    output logic [CNT_W-1:0]       stall_cnt
);

    localparam int unsigned NREGS = 2**ADDR_W;

    if (INSTR_W < 3*ADDR_W+1) begin : g_bad_params
        $error("INSTR_W must be at least 3*ADDR_W+1");
    end

    logic [ADDR_W-1:0] dec_rs;
    logic [ADDR_W-1:0] dec_rt;
    logic [ADDR_W-1:0] dec_rd;
    logic [ADDR_W-1:0] dec_dst;
    logic              dst_sel;

    logic [NREGS-1:0]  eff_pending;
    logic              hazard;
    logic              accept;

    logic              out_valid_nxt;
    logic [ADDR_W-1:0] out_rs_nxt;
    logic [ADDR_W-1:0] out_rt_nxt;
    logic [ADDR_W-1:0] out_rd_nxt;
    logic [ADDR_W-1:0] out_dst_nxt;
    logic [NREGS-1:0]  pending_nxt;
    logic [CNT_W-1:0]  stall_cnt_nxt;

    // Field decode
    assign dec_rd  = instr[ADDR_W-1:0];
    assign dec_rt  = instr[2*ADDR_W-1:ADDR_W];
    assign dec_rs  = instr[3*ADDR_W-1:2*ADDR_W];
    assign dst_sel = instr[INSTR_W-1];
    assign dec_dst = dst_sel ? dec_rt : dec_rd;

    // A writeback landing this cycle already satisfies a dependent read
    always_comb begin
        eff_pending = pending;
        if (wb_valid) begin
            eff_pending[wb_addr] = 1'b0;
        end
    end

    assign hazard   = ((dec_rs != '0) && eff_pending[dec_rs])
                    || ((dec_rt != '0) && eff_pending[dec_rt]);
    assign in_ready = !flush && !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign stall    = in_valid && !in_ready;

    // Next-state for output stage, scoreboard and stall counter
    always_comb begin
        out_valid_nxt = out_valid;
        out_rs_nxt    = out_rs;
        out_rt_nxt    = out_rt;
        out_rd_nxt    = out_rd;
        out_dst_nxt   = out_dst;
        pending_nxt   = pending;
        stall_cnt_nxt = stall_cnt;

        if (flush) begin
            out_valid_nxt = 1'b0;
            pending_nxt   = '0;
        end else begin
            if (wb_valid) begin
                pending_nxt[wb_addr] = 1'b0;
            end
            if (accept) begin
                out_valid_nxt = 1'b1;
                out_rs_nxt    = dec_rs;
                out_rt_nxt    = dec_rt;
                out_rd_nxt    = dec_rd;
                out_dst_nxt   = dec_dst;
                // Set after clear so a same-address writeback loses
                if (dec_dst != '0) begin
                    pending_nxt[dec_dst] = 1'b1;
                end
            end else if (out_ready) begin
                out_valid_nxt = 1'b0;
            end
        end
        pending_nxt[0] = 1'b0;

        if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt_nxt = stall_cnt + CNT_W'(1);
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_rs    <= '0;
            out_rt    <= '0;
            out_rd    <= '0;
            out_dst   <= '0;
            pending   <= '0;
            stall_cnt <= '0;
        end else begin
            out_valid <= out_valid_nxt;
            out_rs    <= out_rs_nxt;
            out_rt    <= out_rt_nxt;
            out_rd    <= out_rd_nxt;
            out_dst   <= out_dst_nxt;
            pending   <= pending_nxt;
            stall_cnt <= stall_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_ex_regaddr_scoreboard.sv
// Bench for ex_regaddr_scoreboard: directed scenarios then random traffic
// against an array-based scoreboard model; a CNT_W=2 copy checks saturation.
module tb_ex_regaddr_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] instr;
    logic        flush;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic        out_ready;

    logic        in_ready, out_valid, stall;
    logic [4:0]  out_rs, out_rt, out_rd, out_dst;
    logic [31:0] pending;
    logic [15:0] stall_cnt;

    logic        in_ready2, out_valid2, stall2;
    logic [4:0]  out_rs2, out_rt2, out_rd2, out_dst2;
    logic [31:0] pending2;
    logic [1:0]  stall_cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit      m_pend [32];
    bit      m_ov;
    int      m_rs, m_rt, m_rd, m_dst;
    longint  m_cnt16, m_cnt2;

    always #5 clk = ~clk;

    ex_regaddr_scoreboard u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .instr(instr),
        .in_ready(in_ready), .flush(flush), .wb_valid(wb_valid), .wb_addr(wb_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_rs(out_rs), .out_rt(out_rt),
        .out_rd(out_rd), .out_dst(out_dst), .stall(stall), .pending(pending),
        .stall_cnt(stall_cnt)
    );

    ex_regaddr_scoreboard #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .instr(instr),
        .in_ready(in_ready2), .flush(flush), .wb_valid(wb_valid), .wb_addr(wb_addr),
        .out_valid(out_valid2), .out_ready(out_ready), .out_rs(out_rs2), .out_rt(out_rt2),
        .out_rd(out_rd2), .out_dst(out_dst2), .stall(stall2), .pending(pending2),
        .stall_cnt(stall_cnt2)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_vec();
        logic [31:0] v = '0;
        for (int i = 0; i < 32; i++) v[i] = m_pend[i];
        return v;
    endfunction

    function automatic bit busy(int r, logic wv, logic [4:0] wa);
        return (r != 0) && m_pend[r] && !(wv && (int'(wa) == r));
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        m_ov = 1'b0;
        m_rs = 0; m_rt = 0; m_rd = 0; m_dst = 0;
        m_cnt16 = 0; m_cnt2 = 0;
    endtask

    task automatic check_state();
        chk("out_valid", out_valid, m_ov);
        chk("out_valid_c2", out_valid2, m_ov);
        chk("pending", pending, model_vec());
        chk("pending_c2", pending2, model_vec());
        chk("stall_cnt", stall_cnt, m_cnt16);
        chk("stall_cnt_c2", stall_cnt2, m_cnt2);
        if (m_ov) begin
            chk("out_rs", out_rs, m_rs);
            chk("out_rt", out_rt, m_rt);
            chk("out_rd", out_rd, m_rd);
            chk("out_dst", out_dst, m_dst);
        end
    endtask

    // Asynchronous reset checked before any clock edge, released on a falling edge
    task automatic do_reset();
        in_valid = 0; instr = '0; flush = 0; wb_valid = 0; wb_addr = '0; out_ready = 0;
        rst_n = 1'b0;
        model_clear();
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_fields", {out_rs, out_rt, out_rd, out_dst}, 0);
        chk("rst_pending", pending, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_stall_cnt_c2", stall_cnt2, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step(input logic iv, input logic [15:0] ins, input logic fl,
                        input logic wv, input logic [4:0] wa, input logic ordy);
        int rs, rt, rd, dst;
        bit haz, rdy, acc;
        @(negedge clk);
        in_valid = iv; instr = ins; flush = fl; wb_valid = wv; wb_addr = wa; out_ready = ordy;
        rd  = int'(ins[4:0]);
        rt  = int'(ins[9:5]);
        rs  = int'(ins[14:10]);
        dst = ins[15] ? rt : rd;
        haz = busy(rs, wv, wa) || busy(rt, wv, wa);
        rdy = !fl && !haz && (!m_ov || ordy);
        acc = iv && rdy;
        #1;
        chk("in_ready", in_ready, rdy);
        chk("stall", stall, iv && !rdy);
        if (fl) begin
            m_ov = 1'b0;
            for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        end else begin
            if (wv) m_pend[wa] = 1'b0;
            if (acc) begin
                m_ov = 1'b1;
                m_rs = rs; m_rt = rt; m_rd = rd; m_dst = dst;
                if (dst != 0) m_pend[dst] = 1'b1;
            end else if (ordy) begin
                m_ov = 1'b0;
            end
        end
        if (iv && !rdy) begin
            if (m_cnt16 < 65535) m_cnt16++;
            if (m_cnt2 < 3) m_cnt2++;
        end
        @(posedge clk);
        #1;
        check_state();
    endtask

    initial begin
        rst_n = 1'b0;
        do_reset();

        // Basic accept: rs=1 rt=2 rd=3
        step(1, 16'h0443, 0, 0, 5'd0, 1);
        chk("d031_fields", {out_rs, out_rt, out_rd, out_dst}, {5'd1, 5'd2, 5'd3, 5'd3});
        chk("d031_pending", pending, 32'h8);

        // RAW on r3 stalls until writeback bypass lets it through
        for (int i = 0; i < 3; i++) step(1, 16'h0C04, 0, 0, 5'd0, 1);
        chk("d032_stall_cnt", stall_cnt, 3);
        step(1, 16'h0C04, 0, 1, 5'd3, 1);
        chk("d032_pending", pending, 32'h10);

        // dst_sel picks rt; rd=0 leaves scoreboard alone
        step(1, 16'h8443, 0, 0, 5'd0, 1);
        chk("d033_dst", out_dst, 5'd2);
        step(1, 16'h0400, 0, 0, 5'd0, 1);
        chk("d033_pending", pending, 32'h14);

        // Downstream backpressure holds the output stage
        for (int i = 0; i < 3; i++) step(1, 16'h0C21, 0, 0, 5'd0, 0);
        chk("d034_hold_rd", out_rd, 5'd0);
        step(1, 16'h0C21, 0, 0, 5'd0, 1);
        chk("d034_new_rd", out_rd, 5'd1);

        // Same-address set and clear, then flush
        step(1, 16'h0005, 0, 1, 5'd5, 1);
        chk("d035_bit5", pending[5], 1'b1);
        step(1, 16'h0000, 1, 1, 5'd5, 1);
        chk("d035_flush_pend", pending, 32'h0);
        chk("d035_flush_ov", out_valid, 1'b0);

        // Mid-stall asynchronous reset
        do_reset();
        step(1, 16'h0443, 0, 0, 5'd0, 1);
        for (int i = 0; i < 7; i++) step(1, 16'h0C04, 0, 0, 5'd0, 1);
        chk("d036_cnt7", stall_cnt, 7);
        chk("d036_pend8", pending, 32'h8);
        do_reset();

        // Saturation of the 2-bit counter copy
        step(1, 16'h0400, 0, 0, 5'd0, 1);
        for (int i = 0; i < 6; i++) step(1, 16'h0400, 0, 0, 5'd0, 0);
        chk("d036_cnt2_sat", stall_cnt2, 2'd3);
        chk("d036_cnt16", stall_cnt, 6);

        // Random traffic over a small register window to provoke hazards
        for (int n = 0; n < 2500; n++) begin
            logic [15:0] ins;
            ins = {1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            step(($urandom % 4) != 0, ins, ($urandom % 40) == 0,
                 ($urandom % 2) != 0, 5'($urandom_range(0, 7)), ($urandom % 4) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
